// File: rtl/jstk_pkg.sv
// Shared PmodJSTK definitions: responder state encoding, frame geometry and
// the byte layout of a 5-byte joystick report. The master-side decode uses
// the same byte indices.
package jstk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } jstk_state_e;

  localparam int JSTK_NUM_BYTES   = 5;
  localparam int JSTK_LED_CMD_BIT = 7;

  // Position of each field within the frame, byte 0 transmitted first.
  localparam int BYTE_YLO = 0;
  localparam int BYTE_YHI = 1;
  localparam int BYTE_XLO = 2;
  localparam int BYTE_XHI = 3;
  localparam int BYTE_BTN = 4;

  localparam int JSTK_FRAME_W = 8 * JSTK_NUM_BYTES;

  // Build the report frame; byte 0 lands in the top byte so it shifts out first.
  function automatic logic [JSTK_FRAME_W-1:0] jstk_frame(
    input logic [9:0] posx,
    input logic [9:0] posy,
    input logic [2:0] btn
  );
    logic [7:0]              b [JSTK_NUM_BYTES];
    logic [JSTK_FRAME_W-1:0] f;
    b[BYTE_YLO] = posy[7:0];
    b[BYTE_YHI] = {6'b0, posy[9:8]};
    b[BYTE_XLO] = posx[7:0];
    b[BYTE_XHI] = {6'b0, posx[9:8]};
    b[BYTE_BTN] = {5'b0, btn};
    f = '0;
    for (int i = 0; i < JSTK_NUM_BYTES; i++) begin
      f[8*(JSTK_NUM_BYTES-1-i) +: 8] = b[i];
    end
    return f;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the pin through the synchronizer and keep one extra flop for edges.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/pmodjstk_responder.sv
// PmodJSTK emulator: SPI mode-0 slave that streams a snapshot of X/Y/button
// data each frame and latches the master's command byte (LED control) when
// a complete frame closes.
module pmodjstk_responder
  import jstk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_BYTES   = JSTK_NUM_BYTES
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SS,
  input  logic       SCLK,
  input  logic       MOSI,
  input  logic [9:0] POSX,
  input  logic [9:0] POSY,
  input  logic [2:0] BTN,
  output logic       MISO,
  output logic       MISO_OE,
  output logic [1:0] LED,
  output logic [7:0] CMD_BYTE,
  output logic       FRAME_DONE,
  output logic       BUSY
);

  localparam int BCW = $clog2(NUM_BYTES + 1);

  logic ss_rise, ss_fall, ss_lvl_unused;
  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  // SS idles high, so its synchronizer resets high to avoid a false fall.
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(CLK), .rst_n(RST), .din(SS),
    .level(ss_lvl_unused), .rise(ss_rise), .fall(ss_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(CLK), .rst_n(RST), .din(SCLK),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  // MOSI passes the same depth as SCLK so it lines up with the detected rise.
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(CLK), .rst_n(RST), .din(MOSI),
    .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  jstk_state_e             state;
  logic [JSTK_FRAME_W-1:0] tx_sr;
  logic [7:0]              rx_sr;
  logic [7:0]              cmd_pending;
  logic [2:0]              bit_cnt;
  logic [BCW-1:0]          byte_cnt;
  logic [JSTK_FRAME_W-1:0] frame;
  logic [7:0]              rx_next;

  assign frame   = jstk_frame(POSX, POSY, BTN);
  assign rx_next = {rx_sr[6:0], mosi_lvl};

  // Frame FSM: snapshot on SS fall, shift on SCLK edges, commit on SS rise.
  // NOTE: every register, data paths included, is reset so a mid-frame reset leaves no stale bits.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      tx_sr       <= '0;
      rx_sr       <= '0;
      cmd_pending <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      MISO        <= 1'b0;
      MISO_OE     <= 1'b0;
      LED         <= '0;
      CMD_BYTE    <= '0;
      FRAME_DONE  <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      case (state)
        IDLE: begin
          MISO    <= 1'b0;
          MISO_OE <= 1'b0;
          BUSY    <= 1'b0;
          if (ss_fall) begin
            tx_sr    <= frame;
            MISO     <= frame[JSTK_FRAME_W-1];
            MISO_OE  <= 1'b1;
            BUSY     <= 1'b1;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            // Incomplete frame: drop it without touching LED/CMD_BYTE.
            MISO    <= 1'b0;
            MISO_OE <= 1'b0;
            BUSY    <= 1'b0;
            state   <= IDLE;
          end else if (sclk_rise) begin
            rx_sr   <= rx_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_cnt <= byte_cnt + 1'b1;
              if (byte_cnt == '0) cmd_pending <= rx_next;
              if (byte_cnt == BCW'(NUM_BYTES - 1)) begin
                MISO  <= 1'b0;
                state <= DONE;
              end
            end
          end else if (sclk_fall) begin
            tx_sr <= {tx_sr[JSTK_FRAME_W-2:0], 1'b0};
            MISO  <= tx_sr[JSTK_FRAME_W-2];
          end
        end
        DONE: begin
          MISO <= 1'b0;
          if (ss_rise) begin
            CMD_BYTE <= cmd_pending;
            if (cmd_pending[JSTK_LED_CMD_BIT]) LED <= cmd_pending[1:0];
            FRAME_DONE <= 1'b1;
            MISO_OE    <= 1'b0;
            BUSY       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmodjstk_responder.sv
// Self-checking bench for pmodjstk_responder: a directed vector table,
// hand-written corner sequences, then randomized frames against a model.
module tb_pmodjstk_responder;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       SS = 1'b1;
  logic       SCLK = 1'b0;
  logic       MOSI = 1'b0;
  logic [9:0] POSX = '0;
  logic [9:0] POSY = '0;
  logic [2:0] BTN = '0;
  logic       MISO, MISO_OE, FRAME_DONE, BUSY;
  logic [1:0] LED;
  logic [7:0] CMD_BYTE;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  pmodjstk_responder #(.SYNC_STAGES(2), .NUM_BYTES(5)) dut (
    .CLK(CLK), .RST(RST), .SS(SS), .SCLK(SCLK), .MOSI(MOSI),
    .POSX(POSX), .POSY(POSY), .BTN(BTN),
    .MISO(MISO), .MISO_OE(MISO_OE), .LED(LED), .CMD_BYTE(CMD_BYTE),
    .FRAME_DONE(FRAME_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Count FRAME_DONE pulses, sampled away from the active edge.
  always @(negedge CLK) if (FRAME_DONE === 1'b1) done_cnt++;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference report: five bytes straight from the field definitions.
  function automatic logic [39:0] model_frame(input logic [9:0] x, input logic [9:0] y,
                                              input logic [2:0] b);
    logic [7:0] y_hi, x_hi;
    y_hi = 8'(y / 256);
    x_hi = 8'(x / 256);
    return {y[7:0], y_hi, x[7:0], x_hi, 5'b0, b};
  endfunction

  // Mode-0 master: MOSI changes while SCLK low, MISO sampled just before each rise.
  task automatic spi_xfer(input logic [47:0] mo, input int nbits, input int half,
                          output logic [47:0] mi);
    mi   = '0;
    SS   = 1'b0;
    MOSI = mo[47];
    #200;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mo[47-i];
      #(half);
      mi   = {mi[46:0], MISO};
      SCLK = 1'b1;
      #(half);
      SCLK = 1'b0;
    end
    #200;
    SS   = 1'b1;
    MOSI = 1'b0;
    #200;
  endtask

  typedef struct {
    logic [9:0]  posx;
    logic [9:0]  posy;
    logic [2:0]  btn;
    logic [7:0]  cmd;
    int          nbits;
    int          half;
    logic [47:0] exp_miso;
    int          exp_done;
    logic [1:0]  exp_led;
    logic [7:0]  exp_cmd;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input string tag, input vec_t v);
    logic [47:0] mi;
    int          d0;
    POSX = v.posx;
    POSY = v.posy;
    BTN  = v.btn;
    d0   = done_cnt;
    spi_xfer({v.cmd, 40'h5AC33CA5FF}, v.nbits, v.half, mi);
    check({tag, " miso"}, mi, v.exp_miso);
    check({tag, " frame_done"}, 48'(done_cnt - d0), 48'(v.exp_done));
    check({tag, " led"}, 48'(LED), 48'(v.exp_led));
    check({tag, " cmd_byte"}, 48'(CMD_BYTE), 48'(v.exp_cmd));
    check({tag, " busy"}, 48'(BUSY), 48'(0));
    check({tag, " miso_oe"}, 48'(MISO_OE), 48'(0));
  endtask

  initial begin
    logic [47:0] mi;
    logic [1:0]  model_led;
    logic [7:0]  model_cmd;
    int          d0;
    vec_t        rv;

    vecs[0] = '{10'h2A5, 10'h0F3, 3'b101, 8'h00, 40, 500, 48'hF300A50205,   1, 2'b00, 8'h00};
    vecs[1] = '{10'h123, 10'h3C0, 3'b010, 8'h83, 40, 50,  48'hC003230102,   1, 2'b11, 8'h83};
    vecs[2] = '{10'h3FF, 10'h000, 3'b111, 8'h00, 40, 50,  48'h0000FF0307,   1, 2'b11, 8'h00};
    vecs[3] = '{10'h000, 10'h1AB, 3'b000, 8'h81, 16, 50,  48'hAB01,         0, 2'b11, 8'h00};
    vecs[4] = '{10'h155, 10'h2AA, 3'b100, 8'h82, 40, 50,  48'hAA02550104,   1, 2'b10, 8'h82};
    vecs[5] = '{10'h0FF, 10'h100, 3'b001, 8'h01, 48, 50,  48'h0001FF000100, 1, 2'b10, 8'h01};

    // Reset state while RST is held low.
    #10;
    check("rst miso", 48'(MISO), 48'(0));
    check("rst miso_oe", 48'(MISO_OE), 48'(0));
    check("rst led", 48'(LED), 48'(0));
    check("rst cmd_byte", 48'(CMD_BYTE), 48'(0));
    check("rst frame_done", 48'(FRAME_DONE), 48'(0));
    check("rst busy", 48'(BUSY), 48'(0));
    #10;
    RST = 1'b1;
    #100;

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Position changes after byte 1 must not reach the frame in flight.
    POSX = 10'h000; POSY = 10'h000; BTN = 3'b000;
    fork
      spi_xfer(48'h0, 40, 50, mi);
      begin
        #(200 + 16*100 + 20);
        POSX = 10'h3FF;
        #10;
        check("midframe busy", 48'(BUSY), 48'(1));
        check("midframe miso_oe", 48'(MISO_OE), 48'(1));
      end
    join
    check("snapshot old", mi, 48'h0000000000);
    spi_xfer(48'h0, 40, 50, mi);
    check("snapshot new", mi, 48'h0000FF0300);

    // Reset in the middle of byte 2, after LED has been set.
    POSX = 10'h2A5; POSY = 10'h0F3; BTN = 3'b101;
    spi_xfer({8'h83, 40'h0}, 40, 50, mi);
    check("pre-reset led", 48'(LED), 48'(2'b11));
    SS = 1'b0;
    #200;
    for (int i = 0; i < 20; i++) begin
      #50; SCLK = 1'b1; #50; SCLK = 1'b0;
    end
    #20;
    RST = 1'b0;
    #1;
    check("midrst miso", 48'(MISO), 48'(0));
    check("midrst miso_oe", 48'(MISO_OE), 48'(0));
    check("midrst led", 48'(LED), 48'(0));
    check("midrst cmd_byte", 48'(CMD_BYTE), 48'(0));
    check("midrst busy", 48'(BUSY), 48'(0));
    #9;
    SS = 1'b1;
    #100;
    RST = 1'b1;
    #100;
    d0 = done_cnt;
    spi_xfer(48'h0, 40, 50, mi);
    check("postrst miso", mi, 48'hF300A50205);
    check("postrst frame_done", 48'(done_cnt - d0), 48'(1));

    // Randomized frames: full, aborted and over-long, against the model.
    model_led = 2'b00;
    model_cmd = 8'h00;
    for (int k = 0; k < 12; k++) begin
      rv.posx = 10'($urandom);
      rv.posy = 10'($urandom);
      rv.btn  = 3'($urandom);
      rv.cmd  = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rv.nbits = int'($urandom_range(1, 39));
        1:       rv.nbits = 48;
        default: rv.nbits = 40;
      endcase
      rv.half     = 50;
      rv.exp_miso = {model_frame(rv.posx, rv.posy, rv.btn), 8'h00} >> (48 - rv.nbits);
      rv.exp_done = (rv.nbits >= 40) ? 1 : 0;
      if (rv.nbits >= 40) begin
        model_cmd = rv.cmd;
        if (rv.cmd[7]) model_led = rv.cmd[1:0];
      end
      rv.exp_led = model_led;
      rv.exp_cmd = model_cmd;
      run_vec($sformatf("rand%0d", k), rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
